// File: rtl/decoder3to8_strobe.sv
`default_nettype none
// ============================================================================
//  Module      : decoder3to8_strobe
//  Description : Registered 3-to-8 one-hot strobe generator. A 3-bit code
//                accepted over a valid/ready handshake drives y[code] high
//                for HOLD_CYCLES clocks, then y is held at zero for
//                GAP_CYCLES clocks before the next code can be accepted.
//  Ports       : clk, rst      - clock (rising edge), synchronous reset (high)
//                in_valid/in_ready/code - code handshake (ready only in IDLE)
//                abort         - cancels a running strobe or gap
//                y             - registered one-hot output
//                busy          - high while a strobe or gap is running
//                done          - one-cycle pulse when a strobe ends normally
//                code_par, err - only with DECODER3TO8_PARITY_EN: odd parity
//                                bit for code, and a one-cycle error pulse
//  Options     : `define DECODER3TO8_PARITY_EN enables the parity check.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder3to8_strobe #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] code,
`ifdef DECODER3TO8_PARITY_EN
    input  logic       code_par,
    output logic       err,
`endif
    input  logic       abort,
    output logic [7:0] y,
    output logic       busy,
    output logic       done
);

    // Counters are loaded with N-1 so that "cnt==0" marks the last cycle.
    localparam logic [CNT_W-1:0] c_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LOAD  =
        (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
    localparam bit c_HAS_GAP = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_y;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       w_onehot;
    logic             w_code_ok;

    assign w_onehot = 8'(1) << code;

`ifdef DECODER3TO8_PARITY_EN
    logic r_err;
    // Odd parity over {code, code_par}: a bad word is consumed but never strobed.
    assign w_code_ok = ^{code, code_par};
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == ST_IDLE) && in_valid && !w_code_ok;
        end
    end
`else
    assign w_code_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_y     <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // abort is meaningless here; only the handshake matters.
                    if (in_valid && w_code_ok) begin
                        r_y     <= w_onehot;
                        r_cnt   <= c_HOLD_LOAD;
                        r_state <= ST_HOLD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // abort wins over a normal end so no done pulse escapes.
                    if (abort) begin
                        r_y     <= 8'h00;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_y    <= 8'h00;
                        r_done <= 1'b1;
                        if (c_HAS_GAP) begin
                            r_cnt   <= c_GAP_LOAD;
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (abort || (r_cnt == '0)) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_y     <= 8'h00;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (r_state == ST_IDLE);
    assign y        = r_y;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire
